ball_motion_ctrl: RTL

BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

---
 rtl/pong_pkg.sv | 26 ++
 rtl/frame_tick_gen.sv | 18 +
 rtl/ball_motion_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong ball controller.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [2:0] WIN_NONE = 3'd0;
  localparam logic [2:0] WIN_P1   = 3'd1;
  localparam logic [2:0] WIN_P2   = 3'd2;

  localparam int DEF_XINIT        = 320;
  localparam int DEF_YINIT        = 240;
  localparam int DEF_XLIM         = 628;
  localparam int DEF_YLIM         = 463;
  localparam int DEF_P1_X         = 80;
  localparam int DEF_P2_X         = 560;
  localparam int DEF_PAD_HW       = 25;
  localparam int DEF_PAD_HH       = 33;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_WIN_SCORE    = 3;

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the level screenEnd marker into a one-cycle frame tick on its rising edge.
module frame_tick_gen (
  input  logic clock_i,
  input  logic reset_i,
  input  logic screen_end_i,
  output logic tick_o
);

  logic se_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) se_q <= 1'b0;
    else         se_q <= screen_end_i;
  end

  assign tick_o = screen_end_i & ~se_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Pong ball motion, paddle/wall bounce, scoring and serve sequencing.
// Optional BALL_SPEEDUP_EN: ball step grows by one per paddle hit (max 4).
//   state    | meaning
//   ST_IDLE  | power-up, ball parked, waiting for start
//   ST_SERVE | ball parked, counting serve frames
//   ST_PLAY  | ball moves once per frame tick
//   ST_OVER  | match won, winner held until start
module ball_motion_ctrl
  import pong_pkg::*;
#(
  parameter int XINIT        = DEF_XINIT,
  parameter int YINIT        = DEF_YINIT,
  parameter int XLIM         = DEF_XLIM,
  parameter int YLIM         = DEF_YLIM,
  parameter int P1_X         = DEF_P1_X,
  parameter int P2_X         = DEF_P2_X,
  parameter int PAD_HW       = DEF_PAD_HW,
  parameter int PAD_HH       = DEF_PAD_HH,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       start,
  input  logic [8:0] p1_y,
  input  logic [8:0] p2_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [2:0] winner,
  output logic       serving
);

  localparam int P1_LO_I = P1_X - PAD_HW;
  localparam int P1_HI_I = P1_X + PAD_HW;
  localparam int P2_LO_I = P2_X - PAD_HW;
  localparam int P2_HI_I = P2_X + PAD_HW;
  localparam int SERVE_LAST_I = SERVE_FRAMES - 1;

  localparam logic signed [11:0] XLIM_S = XLIM[11:0];
  localparam logic signed [11:0] YLIM_S = YLIM[11:0];
  localparam logic signed [11:0] HH_S   = PAD_HH[11:0];
  localparam logic signed [11:0] P1_LO  = P1_LO_I[11:0];
  localparam logic signed [11:0] P1_HI  = P1_HI_I[11:0];
  localparam logic signed [11:0] P2_LO  = P2_LO_I[11:0];
  localparam logic signed [11:0] P2_HI  = P2_HI_I[11:0];
  localparam logic [15:0] SERVE_LAST    = SERVE_LAST_I[15:0];
  localparam logic [3:0]  WIN_S         = WIN_SCORE[3:0];
  localparam logic [9:0]  X0            = XINIT[9:0];
  localparam logic [8:0]  Y0            = YINIT[8:0];

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        xdir_q, xdir_d;  // 1 = moving right
  logic        ydir_q, ydir_d;  // 1 = moving down
  logic [3:0]  s1_q, s1_d, s2_q, s2_d;
  logic [2:0]  win_q, win_d;
  logic [15:0] cnt_q, cnt_d;
  logic        serving_q;
  logic        tick, hit, serve_load;
  logic [2:0]  step;
  logic signed [11:0] stp, nx, ny, py1, py2;
  logic        p1_hit, p2_hit;

  frame_tick_gen u_tick (
    .clock_i      (clock),
    .reset_i      (reset),
    .screen_end_i (screenEnd),
    .tick_o       (tick)
  );

  assign stp = $signed({9'b0, step});
  assign nx  = $signed({2'b00, x_q}) + (xdir_q ? stp : -stp);
  assign ny  = $signed({3'b000, y_q}) + (ydir_q ? stp : -stp);
  assign py1 = $signed({3'b000, p1_y});
  assign py2 = $signed({3'b000, p2_y});
  assign p1_hit = (nx >= P1_LO) && (nx <= P1_HI) && (ny >= py1 - HH_S) && (ny <= py1 + HH_S);
  assign p2_hit = (nx >= P2_LO) && (nx <= P2_HI) && (ny >= py2 - HH_S) && (ny <= py2 + HH_S);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    xdir_d     = xdir_q;
    ydir_d     = ydir_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    hit        = 1'b0;
    serve_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d    = ST_SERVE;
          s1_d       = '0;
          s2_d       = '0;
          win_d      = WIN_NONE;
          xdir_d     = 1'b1;
          ydir_d     = 1'b0;
          cnt_d      = '0;
          serve_load = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
          else                     cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if ((!xdir_q && nx <= 12'sd0) || (xdir_q && nx >= XLIM_S)) begin
            // xdir is left as is: it already points at the player who was scored on
            if (xdir_q) s1_d = s1_q + 4'd1;
            else        s2_d = s2_q + 4'd1;
            x_d        = X0;
            y_d        = Y0;
            ydir_d     = 1'b0;
            cnt_d      = '0;
            serve_load = 1'b1;
            if (xdir_q && s1_d == WIN_S) begin
              state_d = ST_OVER;
              win_d   = WIN_P1;
            end else if (!xdir_q && s2_d == WIN_S) begin
              state_d = ST_OVER;
              win_d   = WIN_P2;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            if ((!xdir_q && p1_hit) || (xdir_q && p2_hit)) begin
              hit    = 1'b1;
              xdir_d = ~xdir_q;
            end else if (nx < 12'sd0) begin
              x_d = '0;
            end else if (nx > XLIM_S) begin
              x_d = XLIM[9:0];
            end else begin
              x_d = nx[9:0];
            end
            if (ny <= 12'sd0) begin
              y_d    = '0;
              ydir_d = ~ydir_q;
            end else if (ny >= YLIM_S) begin
              y_d    = YLIM[8:0];
              ydir_d = ~ydir_q;
            end else begin
              y_d = ny[8:0];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= X0;
      y_q       <= Y0;
      xdir_q    <= 1'b1;
      ydir_q    <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      win_q     <= WIN_NONE;
      cnt_q     <= '0;
      serving_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xdir_q    <= xdir_d;
      ydir_q    <= ydir_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      serving_q <= (state_d == ST_SERVE);
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [2:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (serve_load)                   step_d = 3'd1;
    else if (hit && step_q != 3'd4)   step_d = step_q + 3'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) step_q <= 3'd1;
    else       step_q <= step_d;
  end

  assign step = step_q;
`else
  logic unused_speed;
  assign unused_speed = hit ^ serve_load;
  assign step = 3'd1;
`endif

  assign ball_x  = x_q;
  assign ball_y  = y_q;
  assign winner  = win_q;
  assign serving = serving_q;

endmodule
